bin_to_bcd_serial: RTL

//  Parametrised sequential binary-to-BCD converter (shift-and-add-3 / double-dabble).

---
 rtl/bin2bcd_pkg.sv | 17 +
 rtl/bcd_digit_adj.sv | 14 +
 rtl/bin_to_bcd_serial.sv | 105 ++++++++++
 3 files changed

// File: rtl/bin2bcd_pkg.sv
// Shared types and helpers for the serial binary-to-BCD converter.
package bin2bcd_pkg;

  localparam int unsigned BCD_DIGIT_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  // Decimal digits needed to hold any WIDTH-bit value: ceil(width*log10(2)).
  function automatic int unsigned min_digits(input int unsigned width);
    return (width * 30103 + 99999) / 100000;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: add 3 to a BCD digit that is 5 or more.
module bcd_digit_adj
  import bin2bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit,
  output logic [BCD_DIGIT_W-1:0] adj
);

  always_comb begin
    adj = digit;
    if (digit >= 4'd5) adj = digit + 4'd3;
  end

endmodule

// File: rtl/bin_to_bcd_serial.sv
// Sequential shift-and-add-3 binary-to-BCD converter with valid/ready on both
// sides and a sticky overflow flag for values that do not fit in DIGITS digits.
module bin_to_bcd_serial
  import bin2bcd_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [WIDTH-1:0]              in_bin,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [BCD_DIGIT_W*DIGITS-1:0] out_bcd,
  output logic                          overflow
);

  localparam int unsigned BW = BCD_DIGIT_W * DIGITS;
  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t          state, state_nx;
  logic [CW-1:0]   cnt;
  logic [WIDTH-1:0] bin_q;
  logic [BW-1:0]   bcd_q, bcd_adj, bcd_sh, out_bcd_q;
  logic            ovf_q, ovf_sh, ovf_out_q;
  logic            accept, last;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit (bcd_q[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .adj   (bcd_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  // Bit leaving the top digit means the value has reached 10**DIGITS.
  assign bcd_sh = {bcd_adj[BW-2:0], bin_q[WIDTH-1]};
  assign ovf_sh = ovf_q | bcd_adj[BW-1];
  assign last   = (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // in_ready is held low while reset is asserted so every output reads 0.
  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        in_ready = rst_n;
        if (in_valid) begin
          accept   = 1'b1;
          state_nx = SHIFT;
        end
      end
      SHIFT: begin
        if (last) state_nx = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready & rst_n;
        if (out_ready) begin
          accept   = in_valid;
          state_nx = in_valid ? SHIFT : IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      bin_q     <= '0;
      bcd_q     <= '0;
      ovf_q     <= 1'b0;
      out_bcd_q <= '0;
      ovf_out_q <= 1'b0;
    end else if (accept) begin
      cnt   <= '0;
      bin_q <= in_bin;
      bcd_q <= '0;
      ovf_q <= 1'b0;
    end else if (state == SHIFT) begin
      cnt   <= cnt + CW'(1);
      bin_q <= bin_q << 1;
      bcd_q <= bcd_sh;
      ovf_q <= ovf_sh;
      if (last) begin
        out_bcd_q <= bcd_sh;
        ovf_out_q <= ovf_sh;
      end
    end
  end

  assign out_bcd  = out_bcd_q;
  assign overflow = ovf_out_q;

endmodule
